// File: rtl/logicnet_layer_sequencer.sv
// Time-multiplexed evaluator for one sparse LogicNet layer: one shared truth-table RAM,
// one connectivity RAM, neurons evaluated serially at three cycles each.
module logicnet_layer_sequencer #(
  parameter int N_IN   = 16,
  parameter int N_OUT  = 8,
  parameter int FANIN  = 3,
  parameter int BW     = 2,
  parameter int IDX_W  = 4,
  parameter int TAB_AW = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*BW-1:0]       in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT*BW-1:0]      out_data,
  input  logic                     cfg_we,
  input  logic                     cfg_sel,
  input  logic [TAB_AW-1:0]        cfg_addr,
  input  logic [FANIN*IDX_W-1:0]   cfg_wdata,
  output logic                     cfg_ready,
  output logic                     busy
);

  // state | meaning
  // IDLE  | accept a vector and config writes
  // RCONN | read connectivity word for neuron n
  // RTAB  | gather activations, read truth table
  // WRES  | store table output into slot n
  // DONE  | hold result until out_ready
  typedef enum logic [2:0] {S_IDLE, S_RCONN, S_RTAB, S_WRES, S_DONE} state_e;

  localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int CW = FANIN * IDX_W;
  localparam int GW = FANIN * BW;

  state_e               state_q, state_d;
  logic [NW-1:0]        n_q, n_d;
  logic [N_IN*BW-1:0]   act_q, act_d;
  logic [N_OUT*BW-1:0]  out_data_q, out_data_d;

  logic [BW-1:0]        tab_mem  [2**TAB_AW];
  logic [CW-1:0]        conn_mem [N_OUT];
  logic [CW-1:0]        conn_rd_q;
  logic [BW-1:0]        tab_rd_q;
  logic [GW-1:0]        gather;
  logic [TAB_AW-1:0]    tab_raddr;
  logic                 cfg_wr;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign cfg_ready = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign cfg_wr    = cfg_we && cfg_ready;

  // Out-of-range connectivity indices select a zero activation.
  always_comb begin
    logic [IDX_W-1:0] idx;
    gather = '0;
    for (int f = 0; f < FANIN; f++) begin
      idx = conn_rd_q[f*IDX_W +: IDX_W];
      if (int'(idx) < N_IN) gather[f*BW +: BW] = act_q[idx*BW +: BW];
    end
  end

  assign tab_raddr = TAB_AW'({n_q, gather});

  // RAMs are deliberately outside the reset domain so tables survive a reset.
  always_ff @(posedge clk) begin
    if (cfg_wr && !cfg_sel) tab_mem[cfg_addr] <= cfg_wdata[BW-1:0];
    if (cfg_wr && cfg_sel)  conn_mem[cfg_addr[NW-1:0]] <= cfg_wdata;
    if (state_q == S_RCONN) conn_rd_q <= conn_mem[n_q];
    if (state_q == S_RTAB)  tab_rd_q <= tab_mem[tab_raddr];
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    act_d      = act_q;
    out_data_d = out_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          act_d   = in_data;
          n_d     = '0;
          state_d = S_RCONN;
        end
      end
      S_RCONN: state_d = S_RTAB;
      S_RTAB:  state_d = S_WRES;
      S_WRES: begin
        out_data_d[n_q*BW +: BW] = tab_rd_q;
        if (n_q == NW'(N_OUT - 1)) begin
          state_d = S_DONE;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = S_RCONN;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      act_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      act_q      <= act_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_logicnet_layer_sequencer.sv
// Randomized bench for logicnet_layer_sequencer against an array-based layer model.
module tb_logicnet_layer_sequencer;
  localparam int N_IN = 16, N_OUT = 8, FANIN = 3, BW = 2, IDX_W = 4, TAB_AW = 9;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, cfg_we, cfg_sel;
  logic in_ready, out_valid, cfg_ready, busy;
  logic [N_IN*BW-1:0]     in_data;
  logic [N_OUT*BW-1:0]    out_data;
  logic [TAB_AW-1:0]      cfg_addr;
  logic [FANIN*IDX_W-1:0] cfg_wdata;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0]          tab_m  [2**TAB_AW];
  logic [FANIN*IDX_W-1:0] conn_m [N_OUT];

  logicnet_layer_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_cfg(input logic sel, input logic [TAB_AW-1:0] addr,
                           input logic [FANIN*IDX_W-1:0] data);
    if (!sel) tab_m[addr] = data[BW-1:0];
    else      conn_m[addr % N_OUT] = data;
  endtask

  task automatic cfg_write(input logic sel, input logic [TAB_AW-1:0] addr,
                           input logic [FANIN*IDX_W-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
    model_cfg(sel, addr, data);
  endtask

  // Table address neuron n looks up for a given input vector.
  function automatic int model_addr(input int n, input logic [N_IN*BW-1:0] vec);
    int addr, idx, a;
    addr = n * (2 ** (FANIN*BW));
    for (int f = 0; f < FANIN; f++) begin
      idx  = int'(conn_m[n][f*IDX_W +: IDX_W]);
      a    = (idx < N_IN) ? int'(vec[idx*BW +: BW]) : 0;
      addr = addr + a * (2 ** (f*BW));
    end
    return addr;
  endfunction

  function automatic logic [N_OUT*BW-1:0] model_out(input logic [N_IN*BW-1:0] vec);
    logic [N_OUT*BW-1:0] r;
    r = '0;
    for (int n = 0; n < N_OUT; n++) r[n*BW +: BW] = tab_m[model_addr(n, vec)];
    return r;
  endfunction

  task automatic start_vec(input logic [N_IN*BW-1:0] vec);
    in_valid = 1'b1; in_data = vec;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int lat0, input logic [N_OUT*BW-1:0] exp);
    int lat;
    lat = lat0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 24);
    check_eq({tag, "_data"}, out_data, exp);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("idle_after_ready", busy, 1'b0);
  endtask

  initial begin
    logic [N_IN*BW-1:0]  v;
    logic [N_OUT*BW-1:0] exp;
    int a;

    rst = 1'b1; in_valid = 1'b1; in_data = '1; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) begin
      tick();
      check_eq("rst_in_ready", in_ready, 1'b0);
      check_eq("rst_cfg_ready", cfg_ready, 1'b0);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_out_data", out_data, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("post_rst_in_ready", in_ready, 1'b1);
    check_eq("post_rst_cfg_ready", cfg_ready, 1'b1);
    check_eq("post_rst_busy", busy, 1'b0);

    // Constant tables: slot n reads n%4 regardless of the vector.
    for (int n = 0; n < N_OUT; n++) cfg_write(1'b1, TAB_AW'(n), 12'($urandom));
    for (int i = 0; i < 2**TAB_AW; i++) cfg_write(1'b0, TAB_AW'(i), 12'((i >> 6) % 4));
    v = $urandom;
    start_vec(v);
    wait_result("const", 0, 16'hE4E4);
    release_result();

    // Gather path through neuron 0: conn {15,0,5}.
    cfg_write(1'b1, TAB_AW'(0), {4'd15, 4'd0, 4'd5});
    for (int i = 0; i < 64; i++) cfg_write(1'b0, TAB_AW'(i), 12'(i % 4));
    v = '0; v[11:10] = 2'b11;
    start_vec(v);
    wait_result("gather_a", 0, model_out(v));
    check_eq("gather_a_slot0", out_data[1:0], 2'd3);
    release_result();
    for (int i = 0; i < 64; i++) cfg_write(1'b0, TAB_AW'(i), 12'((i >> 4) % 4));
    v = '0; v[31:30] = 2'b10;
    start_vec(v);
    wait_result("gather_b", 0, model_out(v));
    check_eq("gather_b_slot0", out_data[1:0], 2'd2);
    release_result();

    // Random connectivity/tables; odd rounds write a live table entry in the accept cycle.
    for (int k = 0; k < 10; k++) begin
      repeat (4) cfg_write(1'b1, TAB_AW'($urandom_range(0, N_OUT-1)), 12'($urandom));
      repeat (20) cfg_write(1'b0, TAB_AW'($urandom_range(0, 2**TAB_AW-1)), 12'($urandom_range(0, 3)));
      v = $urandom;
      if (k % 2 == 1) begin
        a = model_addr($urandom_range(0, N_OUT-1), v);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = TAB_AW'(a); cfg_wdata = 12'($urandom_range(0, 3));
        model_cfg(1'b0, cfg_addr, cfg_wdata);
        in_valid = 1'b1; in_data = v;
        tick();
        in_valid = 1'b0; cfg_we = 1'b0;
      end else begin
        start_vec(v);
      end
      wait_result("rand", 0, model_out(v));
      release_result();
    end

    // Backpressure: result held, second vector ignored.
    v = $urandom;
    exp = model_out(v);
    start_vec(v);
    wait_result("bp", 0, exp);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin in_valid = 1'b1; in_data = ~v; end
      tick();
      in_valid = 1'b0;
      check_eq("bp_out_valid", out_valid, 1'b1);
      check_eq("bp_out_data", out_data, exp);
      check_eq("bp_in_ready", in_ready, 1'b0);
    end
    release_result();
    check_eq("bp_in_ready_idle", in_ready, 1'b1);
    tick();
    check_eq("bp_no_restart", busy, 1'b0);
    check_eq("bp_data_hold", out_data, exp);

    // Config write while busy is dropped; the same write in IDLE lands.
    cfg_write(1'b1, TAB_AW'(0), 12'h000);
    cfg_write(1'b0, TAB_AW'(0), 12'd3);
    v = '0;
    start_vec(v);
    repeat (5) tick();
    check_eq("busy_cfg_ready", cfg_ready, 1'b0);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = 12'd1;
    tick();
    cfg_we = 1'b0;
    wait_result("cfg_busy", 6, model_out(v));
    check_eq("cfg_busy_slot0", out_data[1:0], 2'd3);
    release_result();
    cfg_write(1'b0, TAB_AW'(0), 12'd1);
    start_vec(v);
    wait_result("cfg_idle", 0, model_out(v));
    check_eq("cfg_idle_slot0", out_data[1:0], 2'd1);
    release_result();

    // Reset mid-run discards the result but keeps the RAMs.
    v = $urandom;
    start_vec(v);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_out_valid", out_valid, 1'b0);
    check_eq("midrst_out_data", out_data, 0);
    check_eq("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("midrst_in_ready", in_ready, 1'b1);
    start_vec(v);
    wait_result("post_midrst", 0, model_out(v));
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
